// File: rtl/decode_pkg.sv
// Shared constants, region descriptor type and the default device map
// for the 16-bit bus address decoder.
package decode_pkg;

    localparam int NUM_DEV = 8;
    localparam int DID_W   = 3;
    localparam int ADDR_W  = 16;

    localparam logic [DID_W-1:0] DID_NONE = 3'd0;

    // One device window: inclusive base/limit plus read-only flag.
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] limit;
        logic              ro;
    } region_t;

    // Default system memory map; index is the device id.
    localparam region_t DEV_MAP [NUM_DEV] = '{
        '{base: 16'h0000, limit: 16'h7FFF, ro: 1'b1},  // ROM
        '{base: 16'h8000, limit: 16'hBFFF, ro: 1'b0},  // RAM
        '{base: 16'hC000, limit: 16'hDFFF, ro: 1'b0},  // VRAM
        '{base: 16'hF000, limit: 16'hF0FF, ro: 1'b0},  // UART
        '{base: 16'hF100, limit: 16'hF1FF, ro: 1'b0},  // TIMER
        '{base: 16'hF200, limit: 16'hF2FF, ro: 1'b0},  // GPIO
        '{base: 16'hF300, limit: 16'hF3FF, ro: 1'b0},  // ALU coproc
        '{base: 16'hFF00, limit: 16'hFFFF, ro: 1'b0}   // vectors/IRQ
    };

    // Packed views of the default map, used as module parameter defaults.
    function automatic logic [NUM_DEV-1:0][ADDR_W-1:0] default_base();
        logic [NUM_DEV-1:0][ADDR_W-1:0] res;
        for (int i = 0; i < NUM_DEV; i++) res[i] = DEV_MAP[i].base;
        return res;
    endfunction

    function automatic logic [NUM_DEV-1:0][ADDR_W-1:0] default_limit();
        logic [NUM_DEV-1:0][ADDR_W-1:0] res;
        for (int i = 0; i < NUM_DEV; i++) res[i] = DEV_MAP[i].limit;
        return res;
    endfunction

    function automatic logic [NUM_DEV-1:0] default_ro();
        logic [NUM_DEV-1:0] res;
        for (int i = 0; i < NUM_DEV; i++) res[i] = DEV_MAP[i].ro;
        return res;
    endfunction

endpackage

// File: rtl/region_match.sv
// Single-window comparator: flags an address inside [base, limit], both
// bounds inclusive, unsigned compare.
module region_match
    import decode_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic              in_range
);

    // Inclusive range check on both ends.
    always_comb begin
        in_range = (addr >= base) && (addr <= limit);
    end

endmodule

// File: rtl/addr_decode.sv
// Registered bus address decoder: one comparator per device, lowest-index
// priority select, strobe and read-only qualification, one output flop stage.
module addr_decode
    import decode_pkg::*;
#(
    parameter logic [NUM_DEV-1:0][ADDR_W-1:0] DEV_BASE  = default_base(),
    parameter logic [NUM_DEV-1:0][ADDR_W-1:0] DEV_LIMIT = default_limit(),
    parameter logic [NUM_DEV-1:0]             DEV_RO    = default_ro()
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DID_W-1:0]  did
);

    logic [NUM_DEV-1:0] in_range;
    logic               found;
    logic [DID_W-1:0]   sel;
    logic               hit_next;
    logic [DID_W-1:0]   did_next;
    logic               hit_reg;
    logic [DID_W-1:0]   did_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_region
            region_match u_match (
                .addr     (addr),
                .base     (DEV_BASE[gi]),
                .limit    (DEV_LIMIT[gi]),
                .in_range (in_range[gi])
            );
        end
    endgenerate

    // Priority encode (lowest index wins), then qualify by strobe and RO.
    always_comb begin
        found    = 1'b0;
        sel      = DID_NONE;
        hit_next = 1'b0;
        did_next = DID_NONE;
        // Scan downward so the last (lowest) matching index is kept.
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (in_range[i]) begin
                found = 1'b1;
                sel   = i[DID_W-1:0];
            end
        end
        // Exactly one strobe must be active; writes to read-only windows miss.
        hit_next = (rd ^ wr) && found && !(wr && DEV_RO[sel]);
        did_next = hit_next ? sel : DID_NONE;
    end

    // Output register stage, cleared asynchronously so no stale access survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_reg <= 1'b0;
            did_reg <= DID_NONE;
        end else begin
            hit_reg <= hit_next;
            did_reg <= did_next;
        end
    end

    assign hit = hit_reg;
    assign did = did_reg;

endmodule

// File: tb/tb_addr_decode.sv
// Self-checking bench for addr_decode: directed spec scenarios followed by
// random accesses compared against a behavioural address-map model.
module tb_addr_decode;

    logic        clk;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic        hit;
    logic [2:0]  did;

    int total = 0;
    int bad   = 0;

    // Reference memory map written straight from the device table.
    int unsigned ref_base  [8] = '{32'h0000, 32'h8000, 32'hC000, 32'hF000,
                                   32'hF100, 32'hF200, 32'hF300, 32'hFF00};
    int unsigned ref_limit [8] = '{32'h7FFF, 32'hBFFF, 32'hDFFF, 32'hF0FF,
                                   32'hF1FF, 32'hF2FF, 32'hF3FF, 32'hFFFF};
    bit          ref_ro    [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    addr_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .hit   (hit),
        .did   (did)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected {hit, did} for one access.
    function automatic logic [3:0] model(input logic r, input logic w, input logic [15:0] a);
        int unsigned av;
        av = a;
        if (r == w) return 4'h0;
        for (int i = 0; i < 8; i++) begin
            if (av >= ref_base[i] && av <= ref_limit[i]) begin
                if (w && ref_ro[i]) return 4'h0;
                return {1'b1, 3'(i)};
            end
        end
        return 4'h0;
    endfunction

    task automatic check(input string tag, input logic [3:0] expv);
        logic [3:0] obs;
        obs = {hit, did};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed hit=%b did=%0d expected hit=%b did=%0d",
                   tag, obs[3], obs[2:0], expv[3], expv[2:0]);
        end
    endtask

    // Drive one access, clock it in, check the registered result.
    task automatic step(input string tag, input logic r, input logic w, input logic [15:0] a);
        logic [3:0] expv;
        rd = r; wr = w; addr = a;
        expv = model(r, w, a);
        @(posedge clk);
        #1;
        check(tag, expv);
        $display("%s rd=%b wr=%b addr=%h -> hit=%b did=%0d", tag, r, w, a, hit, did);
    endtask

    initial begin
        logic [15:0] ra;
        logic [1:0]  rs;
        rst_n = 1'b0; rd = 1'b1; wr = 1'b0; addr = 16'h8000;

        // Reset holds outputs low with no clock edge needed.
        #1;
        check("reset_initial", 4'h0);
        @(posedge clk); #1;
        check("reset_held", 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release_first", {1'b1, 3'd1});

        // Async reset mid-stream clears a live hit immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_clear", 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        check("reset_no_stale", 4'h0);

        // Boundary read sweep.
        step("sweep_0000", 1, 0, 16'h0000);
        step("sweep_7FFF", 1, 0, 16'h7FFF);
        step("sweep_8000", 1, 0, 16'h8000);
        step("sweep_BFFF", 1, 0, 16'hBFFF);
        step("sweep_C000", 1, 0, 16'hC000);
        step("sweep_DFFF", 1, 0, 16'hDFFF);
        step("sweep_F000", 1, 0, 16'hF000);
        step("sweep_F0FF", 1, 0, 16'hF0FF);
        step("sweep_F100", 1, 0, 16'hF100);
        step("sweep_F2FF", 1, 0, 16'hF2FF);
        step("sweep_F300", 1, 0, 16'hF300);
        step("sweep_F3FF", 1, 0, 16'hF3FF);
        step("sweep_FF00", 1, 0, 16'hFF00);
        step("sweep_FFFF", 1, 0, 16'hFFFF);

        // Holes.
        step("hole_E000", 1, 0, 16'hE000);
        step("hole_EFFF", 1, 0, 16'hEFFF);
        step("hole_F400", 1, 0, 16'hF400);
        step("hole_FEFF", 1, 0, 16'hFEFF);

        // Read-only ROM behaviour.
        step("ro_write", 0, 1, 16'h1234);
        step("ro_read",  1, 0, 16'h1234);
        step("rw_write", 0, 1, 16'h9000);

        // Strobe qualification.
        step("strobe_idle",    0, 0, 16'h8000);
        step("strobe_illegal", 1, 1, 16'h8000);

        // Back-to-back accesses on consecutive cycles.
        step("b2b_rd_C000", 1, 0, 16'hC000);
        step("b2b_wr_F200", 0, 1, 16'hF200);
        step("b2b_idle",    0, 0, 16'hF200);

        // Random accesses, biased half the time toward region edges.
        for (int n = 0; n < 300; n++) begin
            rs = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                ra = 16'($urandom_range(0, 16'hFFFF));
            end else begin
                ra = 16'(($urandom_range(0, 1) == 0) ? ref_base[$urandom_range(0, 7)]
                                                     : ref_limit[$urandom_range(0, 7)]);
                ra = ra + 16'($urandom_range(0, 2)) - 16'd1;
            end
            step("random", rs[1], rs[0], ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
